mem_wb_stage: RTL

// - Memory stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register.
// - Resolves the branch, drives the data-memory request/response handshake and sizes loads/stores.
// - Stalls the pipe while memory is busy and registers the results for the write-back stage.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_wb_stage_if.sv | 23 ++
 rtl/mem_wb_stage_load_store_align.sv | 49 ++++
 rtl/mem_wb_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory / write-back stage.
package mem_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // Everything the write-back stage consumes
    typedef struct packed {
        logic [1:0]  wb_ctrl;
        logic [31:0] alu;
        logic [31:0] load_data;
        logic [4:0]  rd;
        logic        fault;
    } wb_bundle_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response handshake.
interface mem_wb_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmemReq;
    logic              dmemWe;
    logic [ADDR_W-1:0] dmemAddr;
    logic [3:0]        dmemBe;
    logic [31:0]       dmemWdata;
    logic              dmemReady;
    logic              dmemRvalid;
    logic [31:0]       dmemRdata;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
        input  dmemReady, dmemRvalid, dmemRdata
    );

    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
        output dmemReady, dmemRvalid, dmemRdata
    );
endinterface

// File: rtl/mem_wb_stage_load_store_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension,
// and detection of misaligned or unsupported sizes.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic        i_store,
    input  logic [31:0] i_rd2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Size decode; unsigned variants are load-only, so a store with them is illegal
    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_rd2;
        o_load_data  = 32'h0;
        o_misaligned = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be         = 4'b0001 << i_addr;
                o_wdata      = {4{i_rd2[7:0]}};
                o_load_data  = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_misaligned = i_store & i_funct3[2];
            end
            F3_H, F3_HU: begin
                o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_rd2[15:0]}};
                o_load_data  = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr[0] | (i_store & i_funct3[2]);
            end
            F3_W: begin
                o_be         = 4'b1111;
                o_load_data  = i_rdata;
                o_misaligned = (i_addr != 2'b00);
            end
            default: o_misaligned = 1'b1;
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage + MEM/WB register: branch resolve, data-memory handshake,
// stall generation, access timeout and the write-back register.
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch,
    input  logic                memRead,
    input  logic                memWrite,
    input  logic                zeroOut,
    input  logic [1:0]          wbOut,
    input  logic [31:0]         pcAdderOut,
    input  logic [31:0]         alu,
    input  logic [31:0]         rd2Out,
    input  logic [31:0]         instrOut,
    output logic                pcSrc,
    output logic [31:0]         branchTarget,
    output logic                memStall,
    mem_wb_stage_if.master      dmem,
    output logic [1:0]          wbCtrlW,
    output logic [31:0]         aluW,
    output logic [31:0]         loadDataW,
    output logic [4:0]          rdW,
    output logic                memFault
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    wb_bundle_t       r_w;

    logic        w_mem_op, w_load, w_store, w_misaligned;
    logic        w_retire, w_fault, w_cnt_last;
    logic [31:0] w_load_data;
    logic        w_unused;

    // Read+write together behaves as a load
    assign w_load     = memRead;
    assign w_store    = memWrite & ~memRead;
    assign w_mem_op   = memRead | memWrite;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_unused   = ^{instrOut[31:15], instrOut[6:0]};

    load_store_align u_align (
        .i_funct3     (instrOut[14:12]),
        .i_addr       (alu[1:0]),
        .i_store      (w_store),
        .i_rd2        (rd2Out),
        .i_rdata      (dmem.dmemRdata),
        .o_be         (dmem.dmemBe),
        .o_wdata      (dmem.dmemWdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    assign pcSrc         = branch & zeroOut;
    assign branchTarget  = pcAdderOut;
    assign dmem.dmemReq  = (r_state == REQ);
    assign dmem.dmemWe   = (r_state == REQ) & w_store;
    assign dmem.dmemAddr = {alu[ADDR_W-1:2], 2'b00};

    // Upstream is held frozen whenever the current instruction is not retiring
    assign memStall = ~w_retire;

    // Next state, retire and fault decisions; inputs stay stable while stalled
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_fault  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op && !w_misaligned) begin
                    w_next = REQ;
                end else begin
                    w_retire = 1'b1;
                    w_fault  = w_mem_op;
                end
            end
            REQ: begin
                if (dmem.dmemReady && (w_store || dmem.dmemRvalid)) begin
                    w_retire = 1'b1;
                    w_next   = IDLE;
                end else if (w_cnt_last) begin
                    w_retire = 1'b1;
                    w_fault  = 1'b1;
                    w_next   = IDLE;
                end else if (dmem.dmemReady) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem.dmemRvalid || w_cnt_last) begin
                    w_retire = 1'b1;
                    w_fault  = ~dmem.dmemRvalid;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State and access-age counter; counter sits at zero outside an access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == IDLE || w_retire) ? '0 : r_cnt + 1'b1;
        end
    end

    // W register: loads on retire; a stall cycle presents a bubble downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w <= '0;
        end else if (w_retire) begin
            r_w.wb_ctrl   <= w_fault ? 2'b00 : wbOut;
            r_w.alu       <= alu;
            r_w.load_data <= (w_load && !w_fault) ? w_load_data : 32'h0;
            r_w.rd        <= instrOut[11:7];
            r_w.fault     <= w_fault;
        end else begin
            r_w.wb_ctrl <= 2'b00;
            r_w.fault   <= 1'b0;
        end
    end

    assign wbCtrlW   = r_w.wb_ctrl;
    assign aluW      = r_w.alu;
    assign loadDataW = r_w.load_data;
    assign rdW       = r_w.rd;
    assign memFault  = r_w.fault;
endmodule
